sram_bus_master: RTL and testbench

- AVR-side initiator for the CPLD data bus bridge.
- Turns single-word read/write requests from the host-side logic into timed, glitch-free cs_n/we_n/oe_n strobe sequences.
- Drives address and write data, and captures read data from the shared tristate bus.
- Returns read data on a one-cycle response pulse.

---
 rtl/sram_bus_master.sv | 197 +++++++++++++++++++
 tb/tb_sram_bus_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_master.sv
//==============================================================================
// Module  : sram_bus_master
// Brief   : Single-word bus initiator producing timed cs_n/we_n/oe_n strobes
//           on a shared tristate data bus. Define SRAM_BUS_MASTER_AUTOINC_EN
//           to add the auto-incrementing address pointer (i_req_use_ptr).
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module sram_bus_master #(
   parameter int DWIDTH       = 8,
   parameter int AWIDTH       = 16,
   parameter int SETUP_CYCLES = 1,
   parameter int PULSE_CYCLES = 2,
   parameter int HOLD_CYCLES  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [AWIDTH-1:0] i_req_addr,
   input  logic [DWIDTH-1:0] i_req_wdata,
`ifdef SRAM_BUS_MASTER_AUTOINC_EN
   input  logic              i_req_use_ptr,
`endif
   output logic              o_rsp_valid,
   output logic [DWIDTH-1:0] o_rsp_rdata,
   output logic [AWIDTH-1:0] o_bus_addr,
   inout  wire  [DWIDTH-1:0] io_bus_data,
   output logic              o_bus_cs_n,
   output logic              o_bus_we_n,
   output logic              o_bus_oe_n,
   output logic              o_busy
);

   localparam logic [3:0] c_SETUP_LOAD = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] c_PULSE_LOAD = 4'(PULSE_CYCLES - 1);
   localparam logic [3:0] c_HOLD_LOAD  = 4'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_TURN   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic              r_write;
   logic              w_write_nxt;
   logic [AWIDTH-1:0] r_addr;
   logic [AWIDTH-1:0] w_addr_sel;
   logic [DWIDTH-1:0] r_wdata;
   logic [DWIDTH-1:0] r_rdata;
   logic              r_rsp_valid;
   logic              r_cs_n;
   logic              r_we_n;
   logic              r_oe_n;
   logic              r_drive;
   logic              w_cs_n_nxt;
   logic              w_we_n_nxt;
   logic              w_oe_n_nxt;
   logic              w_drive_nxt;
   logic              w_accept;
   logic              w_last;
   logic              w_capture;

   assign o_req_ready = (r_state == S_IDLE) && !reset;
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_last      = (r_cnt == 4'd0);
   assign w_write_nxt = w_accept ? i_req_write : r_write;
   assign w_capture   = (r_state == S_STROBE) && w_last && !r_write;

`ifdef SRAM_BUS_MASTER_AUTOINC_EN
   logic [AWIDTH-1:0] r_ptr;

   assign w_addr_sel = i_req_use_ptr ? r_ptr : i_req_addr;

   // Pointer always lands one past the address actually used, wrapping naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= w_addr_sel + AWIDTH'(1);
      end
   end
`else
   assign w_addr_sel = i_req_addr;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_SETUP;
               w_cnt_nxt   = c_SETUP_LOAD;
            end
         end
         S_SETUP: begin
            if (w_last) begin
               w_state_nxt = S_STROBE;
               w_cnt_nxt   = c_PULSE_LOAD;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_STROBE: begin
            if (w_last) begin
               if (HOLD_CYCLES > 0) begin
                  w_state_nxt = S_HOLD;
                  w_cnt_nxt   = c_HOLD_LOAD;
               end else begin
                  w_state_nxt = r_write ? S_IDLE : S_TURN;
               end
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_HOLD: begin
            if (w_last) begin
               w_state_nxt = r_write ? S_IDLE : S_TURN;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_TURN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Strobes are decoded from the next state so they come straight off flops.
      w_cs_n_nxt  = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                      (w_state_nxt == S_HOLD));
      w_we_n_nxt  = !((w_state_nxt == S_STROBE) && w_write_nxt);
      w_oe_n_nxt  = !((w_state_nxt == S_STROBE) && !w_write_nxt);
      w_drive_nxt = !w_cs_n_nxt && w_write_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_cs_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_drive <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cs_n  <= w_cs_n_nxt;
         r_we_n  <= w_we_n_nxt;
         r_oe_n  <= w_oe_n_nxt;
         r_drive <= w_drive_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_rsp_valid <= w_capture;
         if (w_capture) begin
            r_rdata <= io_bus_data;
         end
         if (w_accept) begin
            r_write <= i_req_write;
            r_addr  <= w_addr_sel;
            r_wdata <= i_req_wdata;
         end
      end
   end

   assign io_bus_data = r_drive ? r_wdata : {DWIDTH{1'bz}};
   assign o_bus_addr  = r_addr;
   assign o_bus_cs_n  = r_cs_n;
   assign o_bus_we_n  = r_we_n;
   assign o_bus_oe_n  = r_oe_n;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rdata;
   assign o_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_master.sv
//==============================================================================
// Module  : tb_sram_bus_master
// Brief   : Self-checking bench for sram_bus_master with a read-data scoreboard.
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_bus_master;

   localparam int DW = 8;
   localparam int AW = 16;
   localparam logic [DW-1:0] c_IDLE_PAT = 8'h3C;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          f_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          use_ptr = 1'b0;
   logic [DW-1:0] mem_rdata = 8'h5A;

   logic          req_ready, rsp_valid, cs_n, we_n, oe_n, busy;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] bus_addr;
   wire  [DW-1:0] bus_data;

   logic          f_ready, f_rsp_valid, f_cs_n, f_we_n, f_oe_n, f_busy;
   logic [DW-1:0] f_rsp_rdata;
   logic [AW-1:0] f_addr;
   wire  [DW-1:0] f_bus;

   int            n_checks = 0;
   int            n_err = 0;
   logic [DW-1:0] sb_q[$];

   always #5 clk = ~clk;

   // Memory model returns data while oe_n is low; a marker pattern is driven
   // whenever the bus should be released so any stray DUT drive corrupts it.
   logic          w_tb_en;
   logic [DW-1:0] w_tb_val;
   assign w_tb_en  = !oe_n || cs_n;
   assign w_tb_val = !oe_n ? mem_rdata : c_IDLE_PAT;
   assign bus_data = w_tb_en ? w_tb_val : {DW{1'bz}};
   assign f_bus    = !f_oe_n ? mem_rdata : {DW{1'bz}};

   sram_bus_master #(.DWIDTH(DW), .AWIDTH(AW)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_write (req_write),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
`ifdef SRAM_BUS_MASTER_AUTOINC_EN
      .i_req_use_ptr (use_ptr),
`endif
      .o_rsp_valid (rsp_valid),
      .o_rsp_rdata (rsp_rdata),
      .o_bus_addr  (bus_addr),
      .io_bus_data (bus_data),
      .o_bus_cs_n  (cs_n),
      .o_bus_we_n  (we_n),
      .o_bus_oe_n  (oe_n),
      .o_busy      (busy)
   );

   sram_bus_master #(.DWIDTH(DW), .AWIDTH(AW), .PULSE_CYCLES(1), .HOLD_CYCLES(0)) u_dut_fast (
      .clk         (clk),
      .reset       (reset),
      .i_req_valid (f_valid),
      .o_req_ready (f_ready),
      .i_req_write (req_write),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
`ifdef SRAM_BUS_MASTER_AUTOINC_EN
      .i_req_use_ptr (use_ptr),
`endif
      .o_rsp_valid (f_rsp_valid),
      .o_rsp_rdata (f_rsp_rdata),
      .o_bus_addr  (f_addr),
      .io_bus_data (f_bus),
      .o_bus_cs_n  (f_cs_n),
      .o_bus_we_n  (f_we_n),
      .o_bus_oe_n  (f_oe_n),
      .o_busy      (f_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic strobes(input string tag, input logic cs, input logic we, input logic oe);
      check({tag, ".cs_n"}, cs_n, cs);
      check({tag, ".we_n"}, we_n, we);
      check({tag, ".oe_n"}, oe_n, oe);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [AW-1:0] exp_a);
      check("wr.ready", req_ready, 1'b1);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
      tick();
      req_valid = 1'b0;
      check("wr.addr", bus_addr, exp_a);
      check("wr.data", bus_data, d);
      repeat (4) tick();
   endtask

   // Scoreboard: every response pulse must match the oldest outstanding read.
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (sb_q.size() == 0) begin
            check("rsp.unexpected", 1, 0);
         end else begin
            check("rsp.rdata", rsp_rdata, sb_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (f_rsp_valid) check("fast.rsp.unexpected", 1, 0);
   end

   initial begin
      repeat (3) tick();
      strobes("rst", 1'b1, 1'b1, 1'b1);
      check("rst.addr", bus_addr, 16'h0000);
      check("rst.rsp_valid", rsp_valid, 1'b0);
      check("rst.rdata", rsp_rdata, 8'h00);
      check("rst.busy", busy, 1'b0);
      check("rst.ready", req_ready, 1'b0);
      check("rst.data", bus_data, c_IDLE_PAT);
      reset = 1'b0;
      tick();
      check("idle.ready", req_ready, 1'b1);

      // Write 0x1234 <- 0xA5
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1234; req_wdata = 8'hA5;
      tick();
      req_valid = 1'b0;
      strobes("w.c1", 1'b0, 1'b1, 1'b1);
      check("w.c1.addr", bus_addr, 16'h1234);
      check("w.c1.data", bus_data, 8'hA5);
      check("w.c1.ready", req_ready, 1'b0);
      check("w.c1.busy", busy, 1'b1);
      tick();
      strobes("w.c2", 1'b0, 1'b0, 1'b1);
      check("w.c2.data", bus_data, 8'hA5);
      tick();
      strobes("w.c3", 1'b0, 1'b0, 1'b1);
      tick();
      strobes("w.c4", 1'b0, 1'b1, 1'b1);
      check("w.c4.data", bus_data, 8'hA5);
      tick();
      strobes("w.c5", 1'b1, 1'b1, 1'b1);
      check("w.c5.ready", req_ready, 1'b1);
      check("w.c5.busy", busy, 1'b0);
      check("w.c5.data", bus_data, c_IDLE_PAT);

      // Read 0x0042, memory returns 0x5A
      mem_rdata = 8'h5A;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0042;
      sb_q.push_back(8'h5A);
      tick();
      req_valid = 1'b0;
      strobes("r.c1", 1'b0, 1'b1, 1'b1);
      check("r.c1.addr", bus_addr, 16'h0042);
      tick();
      strobes("r.c2", 1'b0, 1'b1, 1'b0);
      check("r.c2.data", bus_data, 8'h5A);
      tick();
      strobes("r.c3", 1'b0, 1'b1, 1'b0);
      tick();
      strobes("r.c4", 1'b0, 1'b1, 1'b1);
      check("r.c4.rsp_valid", rsp_valid, 1'b1);
      tick();
      strobes("r.c5", 1'b1, 1'b1, 1'b1);
      check("r.c5.busy", busy, 1'b1);
      check("r.c5.ready", req_ready, 1'b0);
      check("r.c5.rsp_valid", rsp_valid, 1'b0);
      check("r.c5.data", bus_data, c_IDLE_PAT);
      tick();
      check("r.c6.ready", req_ready, 1'b1);
      check("r.c6.busy", busy, 1'b0);

      // Read 0x0100 followed by write 0x0200 with req_valid held high
      mem_rdata = 8'hC3;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100;
      sb_q.push_back(8'hC3);
      tick();
      req_write = 1'b1; req_addr = 16'h0200; req_wdata = 8'h96;
      for (int c = 1; c <= 5; c++) begin
         check("rw.wait.ready", req_ready, 1'b0);
         if (c == 5) check("rw.turn.data", bus_data, c_IDLE_PAT);
         tick();
      end
      check("rw.accept.ready", req_ready, 1'b1);
      check("rw.accept.data", bus_data, c_IDLE_PAT);
      tick();
      req_valid = 1'b0;
      strobes("rw.setup", 1'b0, 1'b1, 1'b1);
      check("rw.setup.addr", bus_addr, 16'h0200);
      check("rw.setup.data", bus_data, 8'h96);
      repeat (4) tick();
      check("rw.done.ready", req_ready, 1'b1);

      // Reset during the second STROBE cycle of a read
      mem_rdata = 8'hE7;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0077;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      strobes("ab.strobe2", 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      tick();
      strobes("ab.after", 1'b1, 1'b1, 1'b1);
      check("ab.busy", busy, 1'b0);
      check("ab.rsp_valid", rsp_valid, 1'b0);
      check("ab.rdata", rsp_rdata, 8'h00);
      check("ab.data", bus_data, c_IDLE_PAT);
      reset = 1'b0;
      tick();
      check("ab.ready", req_ready, 1'b1);
      check("ab.rsp_valid2", rsp_valid, 1'b0);

      // PULSE_CYCLES=1, HOLD_CYCLES=0 write
      f_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0033; req_wdata = 8'h11;
      check("f.c0.ready", f_ready, 1'b1);
      tick();
      f_valid = 1'b0;
      check("f.c1.cs_n", f_cs_n, 1'b0);
      check("f.c1.we_n", f_we_n, 1'b1);
      check("f.c1.data", f_bus, 8'h11);
      tick();
      check("f.c2.we_n", f_we_n, 1'b0);
      check("f.c2.oe_n", f_oe_n, 1'b1);
      tick();
      check("f.c3.we_n", f_we_n, 1'b1);
      check("f.c3.cs_n", f_cs_n, 1'b1);
      check("f.c3.ready", f_ready, 1'b1);
      check("f.c3.busy", f_busy, 1'b0);

      wr_txn(16'hBEEF, 8'h5C, 16'hBEEF);
`ifdef SRAM_BUS_MASTER_AUTOINC_EN
      use_ptr = 1'b0;
      wr_txn(16'hFFFE, 8'h01, 16'hFFFE);
      use_ptr = 1'b1;
      wr_txn(16'h1111, 8'h02, 16'hFFFF);
      wr_txn(16'h2222, 8'h03, 16'h0000);
      use_ptr = 1'b0;
`endif

      repeat (2) tick();
      check("sb.pending", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
